// File: rtl/mem_stage_pkg.sv
// rtl/mem_stage_pkg.sv - shared types and default widths for the memory stage
package mem_stage_pkg;
  localparam int DATA_W_C = 16;
  localparam int ADDR_W_C = 16;
  localparam int REG_W_C  = 4;

  typedef enum logic {IDLE, LOAD_WAIT} mem_state_e;
  typedef enum logic [1:0] {OP_PASS, OP_LOAD, OP_STORE} op_e;

  function automatic op_e decode_op(input logic mm, input logic wme);
    if (!mm) return OP_PASS;
    return wme ? OP_STORE : OP_LOAD;
  endfunction
endpackage

// File: rtl/mem_access_stage_timer.sv
// rtl/mem_access_stage_timer.sv - mem_load_timer: counts down the data-RAM read latency of a load
module mem_load_timer #(
  parameter int RAM_LATENCY = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic clear,
  output logic done
);
  localparam int CNT_W = $clog2(RAM_LATENCY + 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (start) begin
      cnt <= CNT_W'(RAM_LATENCY - 1);
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign done = (cnt == '0);
endmodule

// File: rtl/mem_access_stage.sv
// rtl/mem_access_stage.sv - CPU memory stage: data-RAM loads/stores with load-latency stall
// Optional store-to-load bypass enabled by defining MEM_BYPASS_EN.
module mem_access_stage
  import mem_stage_pkg::*;
#(
  parameter int DATA_W      = DATA_W_C,
  parameter int ADDR_W      = ADDR_W_C,
  parameter int REG_W       = REG_W_C,
  parameter int RAM_LATENCY = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_mm,
  input  logic              in_wme,
  input  logic              in_wbs,
  input  logic              in_ni,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [DATA_W-1:0] in_wdata,
  input  logic [REG_W-1:0]  in_reg_dest,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_wren,
  input  logic [DATA_W-1:0] ram_q,
  output logic              out_valid,
  output logic              out_wbs,
  output logic              out_ni,
  output logic [DATA_W-1:0] out_mem_data,
  output logic [DATA_W-1:0] out_calc_data,
  output logic [REG_W-1:0]  out_reg_dest
);
  mem_state_e        state;
  op_e               op;
  logic              accept;
  logic              load_start;
  logic              load_done;
  logic              byp_hit;
  logic [DATA_W-1:0] byp_data;
  logic [ADDR_W-1:0] ld_addr;
  logic [REG_W-1:0]  ld_dest;
  logic              ld_wbs;
  logic              ld_ni;

  assign op         = decode_op(in_mm, in_wme);
  assign in_ready   = (state == IDLE);
  assign accept     = in_valid & in_ready & ~flush;
  assign ram_addr   = (state == IDLE) ? in_addr : ld_addr;
  assign ram_wdata  = in_wdata;
  assign ram_wren   = accept && (op == OP_STORE);
  assign load_start = accept && (op == OP_LOAD) && !byp_hit;

`ifdef MEM_BYPASS_EN
  logic              byp_valid;
  logic [ADDR_W-1:0] byp_addr;

  // Record is compared before this cycle's store updates it.
  assign byp_hit = byp_valid && (byp_addr == in_addr);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byp_valid <= 1'b0;
      byp_addr  <= '0;
      byp_data  <= '0;
    end else if (ram_wren) begin
      byp_valid <= 1'b1;
      byp_addr  <= in_addr;
      byp_data  <= in_wdata;
    end
  end
`else
  assign byp_hit  = 1'b0;
  assign byp_data = '0;
`endif

  mem_load_timer #(.RAM_LATENCY(RAM_LATENCY)) u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .start (load_start),
    .clear (flush),
    .done  (load_done)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      ld_addr       <= '0;
      ld_dest       <= '0;
      ld_wbs        <= 1'b0;
      ld_ni         <= 1'b0;
      out_valid     <= 1'b0;
      out_wbs       <= 1'b0;
      out_ni        <= 1'b0;
      out_mem_data  <= '0;
      out_calc_data <= '0;
      out_reg_dest  <= '0;
    end else begin
      out_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (load_start) begin
            state   <= LOAD_WAIT;
            ld_addr <= in_addr;
            ld_dest <= in_reg_dest;
            ld_wbs  <= in_wbs;
            ld_ni   <= in_ni;
          end else if (accept) begin
            out_valid     <= 1'b1;
            out_wbs       <= in_wbs;
            out_ni        <= in_ni;
            out_mem_data  <= (op == OP_LOAD) ? byp_data : '0;
            out_calc_data <= in_addr;
            out_reg_dest  <= in_reg_dest;
          end
        end
        LOAD_WAIT: begin
          // flush wins over a load that completes in the same cycle
          if (flush) begin
            state <= IDLE;
          end else if (load_done) begin
            state         <= IDLE;
            out_valid     <= 1'b1;
            out_wbs       <= ld_wbs;
            out_ni        <= ld_ni;
            out_mem_data  <= ram_q;
            out_calc_data <= ld_addr;
            out_reg_dest  <= ld_dest;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_access_stage.sv
// tb/tb_mem_access_stage.sv - self-checking bench: DUT0 with RAM_LATENCY=1, DUT1 with RAM_LATENCY=3
module tb_mem_access_stage;
  typedef struct {
    logic        mm, wme, wbs, ni;
    logic [15:0] addr, wdata;
    logic [3:0]  dest;
    logic [15:0] exp_mem;
  } vec_t;

  typedef struct {
    logic [15:0] mem, calc;
    logic [3:0]  dest;
    logic        wbs, ni;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush[2], in_valid[2], in_mm[2], in_wme[2], in_wbs[2], in_ni[2];
  logic [15:0] in_addr[2], in_wdata[2];
  logic [3:0]  in_reg_dest[2];
  logic        in_ready[2], ram_wren[2], out_valid[2], out_wbs[2], out_ni[2];
  logic [15:0] ram_addr[2], ram_wdata[2], ram_q[2], out_mem_data[2], out_calc_data[2];
  logic [3:0]  out_reg_dest[2];

  int   checks = 0;
  int   errors = 0;
  exp_t sbq0[$];
  exp_t sbq1[$];
  vec_t tbl[7];

  always #5 clk = ~clk;

  mem_access_stage #(.RAM_LATENCY(1)) dut0 (
    .clk(clk), .rst_n(rst_n), .flush(flush[0]), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .in_mm(in_mm[0]), .in_wme(in_wme[0]), .in_wbs(in_wbs[0]), .in_ni(in_ni[0]),
    .in_addr(in_addr[0]), .in_wdata(in_wdata[0]), .in_reg_dest(in_reg_dest[0]),
    .ram_addr(ram_addr[0]), .ram_wdata(ram_wdata[0]), .ram_wren(ram_wren[0]), .ram_q(ram_q[0]),
    .out_valid(out_valid[0]), .out_wbs(out_wbs[0]), .out_ni(out_ni[0]),
    .out_mem_data(out_mem_data[0]), .out_calc_data(out_calc_data[0]), .out_reg_dest(out_reg_dest[0])
  );

  mem_access_stage #(.RAM_LATENCY(3)) dut1 (
    .clk(clk), .rst_n(rst_n), .flush(flush[1]), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .in_mm(in_mm[1]), .in_wme(in_wme[1]), .in_wbs(in_wbs[1]), .in_ni(in_ni[1]),
    .in_addr(in_addr[1]), .in_wdata(in_wdata[1]), .in_reg_dest(in_reg_dest[1]),
    .ram_addr(ram_addr[1]), .ram_wdata(ram_wdata[1]), .ram_wren(ram_wren[1]), .ram_q(ram_q[1]),
    .out_valid(out_valid[1]), .out_wbs(out_wbs[1]), .out_ni(out_ni[1]),
    .out_mem_data(out_mem_data[1]), .out_calc_data(out_calc_data[1]), .out_reg_dest(out_reg_dest[1])
  );

  // Synchronous RAM models with 1 and 3 cycles of read latency
  logic [15:0] mem0[256];
  logic [15:0] mem1[256];
  logic [15:0] pipe0;
  logic [15:0] pipe1[3];

  always @(posedge clk) begin
    if (ram_wren[0]) mem0[ram_addr[0][7:0]] <= ram_wdata[0];
    if (ram_wren[1]) mem1[ram_addr[1][7:0]] <= ram_wdata[1];
    pipe0    <= mem0[ram_addr[0][7:0]];
    pipe1[0] <= mem1[ram_addr[1][7:0]];
    pipe1[1] <= pipe1[0];
    pipe1[2] <= pipe1[1];
  end
  assign ram_q[0] = pipe0;
  assign ram_q[1] = pipe1[2];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic mm, input logic wme, input logic wbs, input logic ni,
                              input logic [15:0] addr, input logic [15:0] wdata,
                              input logic [3:0] dest, input logic [15:0] exp_mem);
    vec_t v;
    v.mm = mm; v.wme = wme; v.wbs = wbs; v.ni = ni;
    v.addr = addr; v.wdata = wdata; v.dest = dest; v.exp_mem = exp_mem;
    return v;
  endfunction

  task automatic push(input int k, input vec_t v);
    exp_t e;
    e.mem = v.exp_mem; e.calc = v.addr; e.dest = v.dest; e.wbs = v.wbs; e.ni = v.ni;
    if (k == 0) sbq0.push_back(e);
    else        sbq1.push_back(e);
  endtask

  task automatic drive(input int k, input vec_t v);
    in_valid[k] = 1'b1; in_mm[k] = v.mm; in_wme[k] = v.wme; in_wbs[k] = v.wbs; in_ni[k] = v.ni;
    in_addr[k] = v.addr; in_wdata[k] = v.wdata; in_reg_dest[k] = v.dest; flush[k] = 1'b0;
  endtask

  // Called just after a rising edge; returns just after the edge that accepted the op.
  task automatic do_op(input int k, input vec_t v);
    bit got = 0;
    drive(k, v);
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (in_ready[k]) got = 1;
    end
    if (!got) begin
      checks++; errors++;
      $display("FAIL accept_timeout dut%0d addr %h", k, v.addr);
    end else begin
      push(k, v);
    end
    @(posedge clk); #1;
    in_valid[k] = 1'b0;
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      for (int k = 0; k < 2; k++) begin
        if (out_valid[k]) begin
          exp_t e;
          if ((k == 0 && sbq0.size() == 0) || (k == 1 && sbq1.size() == 0)) begin
            checks++; errors++;
            $display("FAIL unexpected_out_valid dut%0d: got calc %h, required no output", k, out_calc_data[k]);
          end else begin
            e = (k == 0) ? sbq0.pop_front() : sbq1.pop_front();
            chk("out_mem_data",  out_mem_data[k],  e.mem);
            chk("out_calc_data", out_calc_data[k], e.calc);
            chk("out_reg_dest",  out_reg_dest[k],  e.dest);
            chk("out_wbs",       out_wbs[k],       e.wbs);
            chk("out_ni",        out_ni[k],        e.ni);
          end
        end
      end
    end
  end

  initial begin
    for (int i = 0; i < 256; i++) begin mem0[i] = '0; mem1[i] = '0; end
    for (int k = 0; k < 2; k++) begin
      flush[k] = 0; in_valid[k] = 0; in_mm[k] = 0; in_wme[k] = 0; in_wbs[k] = 0; in_ni[k] = 0;
      in_addr[k] = 0; in_wdata[k] = 0; in_reg_dest[k] = 0;
    end

    tbl[0] = mk(0, 0, 1, 0, 16'h0005, 16'h0000, 4'd3, 16'h0000);
    tbl[1] = mk(1, 1, 0, 1, 16'h0040, 16'hA5A5, 4'd4, 16'h0000);
    tbl[2] = mk(0, 1, 0, 0, 16'h0010, 16'h5555, 4'd5, 16'h0000);
    tbl[3] = mk(1, 0, 0, 0, 16'h0010, 16'h0000, 4'd6, 16'hBEEF);
    tbl[4] = mk(1, 0, 1, 0, 16'h0040, 16'h0000, 4'd7, 16'hA5A5);
    tbl[5] = mk(1, 1, 0, 0, 16'h0010, 16'hBEEF, 4'd8, 16'h0000);
    tbl[6] = mk(0, 0, 1, 1, 16'hFFFF, 16'h0000, 4'hF, 16'h0000);

    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      chk("reset_in_ready",  in_ready[k],  1);
      chk("reset_out_valid", out_valid[k], 0);
      chk("reset_ram_wren",  ram_wren[k],  0);
      chk("reset_out_calc",  out_calc_data[k], 0);
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // Store then load, latency 1
    drive(0, mk(1, 1, 0, 0, 16'h0010, 16'hBEEF, 4'd1, 16'h0000));
    @(negedge clk);
    chk("store_wren_c0", ram_wren[0], 1);
    chk("store_ready_c0", in_ready[0], 1);
    chk("store_ram_addr", ram_addr[0], 16'h0010);
    chk("store_ram_wdata", ram_wdata[0], 16'hBEEF);
    push(0, mk(1, 1, 0, 0, 16'h0010, 16'hBEEF, 4'd1, 16'h0000));
    @(posedge clk); #1;
    drive(0, mk(1, 0, 0, 0, 16'h0010, 16'h0000, 4'd2, 16'hBEEF));
    @(negedge clk);
    chk("store_wren_c1", ram_wren[0], 0);
    chk("store_valid_c1", out_valid[0], 1);
    push(0, mk(1, 0, 0, 0, 16'h0010, 16'h0000, 4'd2, 16'hBEEF));
    @(posedge clk); #1;
    in_valid[0] = 1'b0; in_addr[0] = 16'hABCD;
    @(negedge clk);
`ifdef MEM_BYPASS_EN
    chk("byp_load_ready_c1", in_ready[0], 1);
    chk("byp_load_valid_c1", out_valid[0], 1);
`else
    chk("load_ready_c1", in_ready[0], 0);
    chk("load_valid_c1", out_valid[0], 0);
    chk("load_ram_addr_latched", ram_addr[0], 16'h0010);
`endif
    @(posedge clk); #1;
    @(negedge clk);
`ifdef MEM_BYPASS_EN
    chk("byp_load_valid_c2", out_valid[0], 0);
`else
    chk("load_valid_c2", out_valid[0], 1);
    chk("load_ready_c2", in_ready[0], 1);
`endif
    @(posedge clk); #1;

    for (int i = 0; i < 7; i++) do_op(0, tbl[i]);

    // Flush in IDLE: store must not write or complete
    drive(0, mk(1, 1, 0, 0, 16'h0010, 16'h1111, 4'd9, 16'h0000));
    flush[0] = 1'b1;
    @(negedge clk);
    chk("flush_idle_wren", ram_wren[0], 0);
    @(posedge clk); #1;
    in_valid[0] = 1'b0; flush[0] = 1'b0;
    @(negedge clk);
    chk("flush_idle_valid", out_valid[0], 0);
    @(posedge clk); #1;
    do_op(0, mk(1, 0, 0, 0, 16'h0010, 16'h0000, 4'd9, 16'hBEEF));
    repeat (3) @(posedge clk);
    #1;

    // Latency 3: load followed by a pass-through held valid
    do_op(1, mk(1, 1, 0, 0, 16'h0020, 16'h7777, 4'd1, 16'h0000));
    do_op(1, mk(1, 1, 0, 0, 16'h0022, 16'h0000, 4'd1, 16'h0000));
    drive(1, mk(1, 0, 1, 0, 16'h0020, 16'h0000, 4'd9, 16'h7777));
    @(negedge clk);
    chk("l3_ready_c0", in_ready[1], 1);
    push(1, mk(1, 0, 1, 0, 16'h0020, 16'h0000, 4'd9, 16'h7777));
    @(posedge clk); #1;
    drive(1, mk(0, 0, 0, 0, 16'h0099, 16'h0000, 4'hA, 16'h0000));
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      chk($sformatf("l3_ready_c%0d", c), in_ready[1], (c >= 4) ? 1 : 0);
      chk($sformatf("l3_valid_c%0d", c), out_valid[1], (c >= 4) ? 1 : 0);
      if (c <= 3) chk("l3_ram_addr", ram_addr[1], 16'h0020);
      if (c == 4) push(1, mk(0, 0, 0, 0, 16'h0099, 16'h0000, 4'hA, 16'h0000));
      @(posedge clk); #1;
      if (c == 4) in_valid[1] = 1'b0;
    end

    // Flush in the first LOAD_WAIT cycle
    drive(1, mk(1, 0, 0, 0, 16'h0020, 16'h0000, 4'd5, 16'h0000));
    @(negedge clk);
    chk("fl_ready_c0", in_ready[1], 1);
    @(posedge clk); #1;
    in_valid[1] = 1'b0; flush[1] = 1'b1;
    @(negedge clk);
    chk("fl_ready_c1", in_ready[1], 0);
    @(posedge clk); #1;
    flush[1] = 1'b0;
    @(negedge clk);
    chk("fl_ready_c2", in_ready[1], 1);
    chk("fl_valid_c2", out_valid[1], 0);
    @(posedge clk); #1;
    do_op(1, mk(0, 0, 0, 1, 16'h0077, 16'h0000, 4'd3, 16'h0000));
    repeat (4) begin
      @(negedge clk);
      chk("fl_no_load_result", (out_valid[1] && out_calc_data[1] == 16'h0020) ? 1 : 0, 0);
    end
    @(posedge clk); #1;

    // Asynchronous reset mid LOAD_WAIT
    drive(1, mk(1, 0, 1, 1, 16'h0020, 16'h0000, 4'd6, 16'h0000));
    @(posedge clk); #1;
    in_valid[1] = 1'b0; in_addr[1] = 16'h3333;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_out_valid", out_valid[1], 0);
    chk("rst_out_calc", out_calc_data[1], 0);
    chk("rst_out_mem", out_mem_data[1], 0);
    chk("rst_out_dest", out_reg_dest[1], 0);
    chk("rst_out_flags", {out_wbs[1], out_ni[1]}, 0);
    chk("rst_in_ready", in_ready[1], 1);
    chk("rst_ram_addr", ram_addr[1], 16'h3333);
    @(posedge clk); #2;
    rst_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("post_rst_ready", in_ready[1], 1);
      chk("post_rst_valid", out_valid[1], 0);
    end
    @(posedge clk); #1;

`ifdef MEM_BYPASS_EN
    do_op(0, mk(1, 1, 0, 0, 16'h0031, 16'h4321, 4'd1, 16'h0000));
    do_op(0, mk(1, 1, 0, 0, 16'h0030, 16'h1234, 4'd1, 16'h0000));
    drive(0, mk(1, 0, 0, 0, 16'h0030, 16'h0000, 4'd2, 16'h1234));
    @(negedge clk);
    chk("byp_ready_c0", in_ready[0], 1);
    push(0, mk(1, 0, 0, 0, 16'h0030, 16'h0000, 4'd2, 16'h1234));
    @(posedge clk); #1;
    in_valid[0] = 1'b0;
    @(negedge clk);
    chk("byp_ready_c1", in_ready[0], 1);
    chk("byp_valid_c1", out_valid[0], 1);
    @(posedge clk); #1;
    drive(0, mk(1, 0, 0, 0, 16'h0031, 16'h0000, 4'd3, 16'h4321));
    @(negedge clk);
    push(0, mk(1, 0, 0, 0, 16'h0031, 16'h0000, 4'd3, 16'h4321));
    @(posedge clk); #1;
    in_valid[0] = 1'b0;
    @(negedge clk);
    chk("byp_miss_stall", in_ready[0], 0);
    @(posedge clk); #1;
`endif

    repeat (6) @(posedge clk);
    #1;
    chk("sb0_drained", sbq0.size(), 0);
    chk("sb1_drained", sbq1.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- Memory stage of the 16-bit pipelined CPU.
- Accepts operations from the Execute/Memory pipeline register, performs data-RAM loads and stores, and presents results to the Memory/Writeback pipeline register.
- Absorbs synchronous-RAM read latency with a small FSM and stalls upstream during load waits.
- Pass-through (non-memory) operations and stores complete in one cycle.

Parameters:
- DATA_W, 16, data word width
- ADDR_W, 16, data-RAM address width
- REG_W, 4, destination register index width
- RAM_LATENCY, 1, read latency of the data RAM in clocks; legal range 1..3

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; asynchronous and active-low
- flush  in  1  squash the current or pending operation
- in_valid  in  1  operation present from Execute
- in_ready  out  1  stage can accept (low = stall Execute)
- in_mm  in  1  1 = memory operation, 0 = ALU pass-through
- in_wme  in  1  with in_mm: 1 = store, 0 = load
- in_wbs  in  1  writeback select, forwarded unchanged
- in_ni  in  1  next-instruction flag, forwarded unchanged
- in_addr  in  ADDR_W  ALU result; address for memory ops, result for pass-through
- in_wdata  in  DATA_W  store data
- in_reg_dest  in  REG_W  destination register index
- ram_addr  out  ADDR_W  data-RAM address
- ram_wdata  out  DATA_W  data-RAM write data
- ram_wren  out  1  data-RAM write enable
- ram_q  in  DATA_W  data-RAM read data
- out_valid  out  1  result valid toward Memory/Writeback
- out_wbs, out_ni  out  1 each  forwarded flags
- out_mem_data  out  DATA_W  load data
- out_calc_data  out  DATA_W  ALU result (in_addr)
- out_reg_dest  out  REG_W  destination index

Behaviour:
- States: IDLE and LOAD_WAIT. Wait counter width is clog2(RAM_LATENCY+1).
- Accept condition: in_valid & in_ready & !flush. in_ready = (state==IDLE); it is 1 after reset.
- ram_addr: equals in_addr in IDLE; equals the latched load address in LOAD_WAIT.
- ram_wdata: always equals in_wdata.
- ram_wren: asserted only on an accept with in_mm=1 and in_wme=1 (purely combinational, single cycle).
- Pass-through or store accepted in cycle 0:
  - Output registers load at the end of cycle 0; out_valid=1 in cycle 1.
  - out_mem_data = 0, out_calc_data = in_addr.
- Load accepted in cycle 0:
  - Go to LOAD_WAIT, latch address and sideband, set cnt = RAM_LATENCY-1.
  - Each LOAD_WAIT cycle with cnt>0 decrements cnt.
  - When cnt==0, capture ram_q into out_mem_data, set out_valid, return to IDLE.
  - Result: in_ready=0 for cycles 1..RAM_LATENCY; out_valid=1 in cycle RAM_LATENCY+1.
- out_valid is a one-cycle pulse per completed operation. It is 0 during LOAD_WAIT (bubble) and 0 in any cycle without a completion.
- Back-to-back pass-through ops: one per cycle. Loads: one per RAM_LATENCY+1 cycles.
- flush in IDLE: no accept, ram_wren=0, out_valid=0 next cycle.
- flush in LOAD_WAIT: abort to IDLE next cycle, no out_valid. A store already written is not undone.
- Reset (any time, including mid-LOAD_WAIT): state=IDLE, cnt=0, and every output register cleared to 0 (out_valid, out_wbs, out_ni, out_mem_data, out_calc_data, out_reg_dest). Combinational outputs follow IDLE rules.
- in_wme=1 with in_mm=0: treated as pass-through; no RAM write.

Optional Feature:
- MEM_BYPASS_EN defined:
  - Keep the last store's address and data plus a valid bit (cleared by reset only).
  - A load in IDLE whose address equals the recorded store address completes as a single-cycle op: out_valid in cycle 1, out_mem_data = recorded data, no stall, no LOAD_WAIT.
  - A store in the same cycle updates the record after that cycle's compare.
- Undefined: every load takes the RAM_LATENCY wait path; no extra state.

Decomposition:
- Package mem_stage_pkg:
  - state enum mem_state_e {IDLE, LOAD_WAIT}
  - default width constants DATA_W_C=16, ADDR_W_C=16, REG_W_C=4
  - an op-type enum {OP_PASS, OP_LOAD, OP_STORE} decoded from in_mm/in_wme
- One sub-module, mem_load_timer: load/decrement counter with a done flag, parameterised by RAM_LATENCY.

Test Plan:
- Pass-through in_addr=0x0005, in_reg_dest=3, in_wbs=1 -> cycle 1: out_valid=1, out_calc_data=0x0005, out_reg_dest=3, no stall.
- Store addr=0x0010 data=0xBEEF -> ram_wren=1 in cycle 0 only, out_valid in cycle 1. Then load addr=0x0010 with RAM_LATENCY=1 -> in_ready=0 in cycle 1, out_mem_data=0xBEEF with out_valid in cycle 2.
- RAM_LATENCY=3, load addr=0x0020 followed by a pass-through held valid -> in_ready low for 3 cycles, load out_valid in cycle 4, pass-through out_valid in cycle 5, ordering preserved.
- Flush in the first LOAD_WAIT cycle -> no out_valid, in_ready=1 next cycle, next op accepted normally.
- Assert rst_n=0 mid-LOAD_WAIT -> all outputs 0 immediately; after release, state IDLE and in_ready=1.
- MEM_BYPASS_EN: store 0x0030=0x1234, then load 0x0030 -> out_valid cycle 1 after load, out_mem_data=0x1234, in_ready never low. Load 0x0031 -> normal stall path.
